// File: rtl/elevator_pkg.sv
// Shared constants for the elevator button matrix: floors, column drive codes and key map.
package elevator_pkg;

  localparam int NUM_FLOORS = 4;

  localparam logic [1:0] FLOOR_1 = 2'd0;
  localparam logic [1:0] FLOOR_2 = 2'd1;
  localparam logic [1:0] FLOOR_3 = 2'd2;
  localparam logic [1:0] FLOOR_4 = 2'd3;

  localparam logic [3:0] COL0_N = 4'b1110;
  localparam logic [3:0] COL1_N = 4'b1101;
  localparam logic [3:0] COL2_N = 4'b1011;
  localparam logic [3:0] COL3_N = 4'b0111;

  // Key index within the 16-key matrix is {column, row}.
  localparam logic [1:0] KEY_CAB_COL        = 2'd0;
  localparam logic [1:0] KEY_UP_COL         = 2'd1;
  localparam logic [1:0] KEY_DOOR_OPEN_COL  = 2'd1;
  localparam logic [1:0] KEY_DOOR_OPEN_ROW  = 2'd3;
  localparam logic [1:0] KEY_DOOR_CLOSE_COL = 2'd2;
  localparam logic [1:0] KEY_DOOR_CLOSE_ROW = 2'd0;
  localparam logic [1:0] KEY_DOWN_COL       = 2'd2;
  localparam logic [1:0] KEY_STOP_COL       = 2'd3;
  localparam logic [1:0] KEY_STOP_ROW       = 2'd0;

  typedef struct packed {
    logic [NUM_FLOORS-1:0] cab;
    logic [NUM_FLOORS-1:0] up;
    logic [NUM_FLOORS-1:0] down;
  } req_vec_t;

  function automatic logic [3:0] key_idx(input logic [1:0] col, input logic [1:0] row);
    return {col, row};
  endfunction

  function automatic logic [3:0] col_code(input logic [1:0] col);
    logic [3:0] code;
    case (col)
      2'd0:    code = COL0_N;
      2'd1:    code = COL1_N;
      2'd2:    code = COL2_N;
      2'd3:    code = COL3_N;
      default: code = COL0_N;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/button_matrix_scanner_if.sv
// Controller-side bus of the button matrix scanner: pending requests, key pulses and the clear handshake.
interface button_matrix_scanner_if;
  logic       clr_valid;
  logic [1:0] clr_floor;
  logic [3:0] cab_req;
  logic [3:0] up_req;
  logic [3:0] down_req;
  logic       any_req;
  logic       stop_pulse;
  logic       door_open_pulse;
  logic       door_close_pulse;

  modport master (
    input  clr_valid, clr_floor,
    output cab_req, up_req, down_req, any_req,
    output stop_pulse, door_open_pulse, door_close_pulse
  );

  modport slave (
    output clr_valid, clr_floor,
    input  cab_req, up_req, down_req, any_req,
    input  stop_pulse, door_open_pulse, door_close_pulse
  );
endinterface

// File: rtl/key_debounce.sv
// Per-key debouncer: counts consecutive sampled disagreements and flips the stable state after enough of them.
module key_debounce #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en_i,
  input  logic raw_i,
  output logic stable_o,
  output logic press_o
);

  localparam logic [3:0] LIMIT = 4'(DEBOUNCE_SCANS);

  logic       stable_q, stable_d;
  logic [3:0] cnt_q, cnt_d;

  // Counter saturates at LIMIT by resetting on the flip, so it never wraps.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_o  = 1'b0;
    if (sample_en_i) begin
      if (raw_i == stable_q) begin
        cnt_d = 4'd0;
      end else if (cnt_q + 4'd1 >= LIMIT) begin
        stable_d = ~stable_q;
        cnt_d    = 4'd0;
        press_o  = raw_i;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= 1'b0;
      cnt_q    <= 4'd0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/button_matrix_scanner.sv
// Scans the 4x4 active-low elevator key matrix, debounces every key, latches floor calls
// until the controller clears them, and pulses the stop/door keys.
module button_matrix_scanner
  import elevator_pkg::*;
#(
  parameter int SCAN_BITS      = 18,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             rows_n,
  output logic [3:0]             col_sel_n,
  button_matrix_scanner_if.master bus
);

  logic [SCAN_BITS-1:0] scan_q, scan_d;
  logic [3:0]           col_sel_n_q;
  logic [1:0]           col_s, col_next_s;
  logic                 sample_s;
  logic [15:0]          press_s;
  logic [15:0]          stable_s;

  req_vec_t             req_q, req_d;
  logic                 any_q, any_d;
  logic                 stop_q, open_q, close_q;
  logic [3:0]           clr_mask_s;
  logic [3:0]           cab_set_s, up_set_s, down_set_s;
  logic                 unused_s;

  assign scan_d     = scan_q + SCAN_BITS'(1);
  assign col_s      = scan_q[SCAN_BITS-1 -: 2];
  assign col_next_s = scan_d[SCAN_BITS-1 -: 2];
  // Rows are sampled on the last cycle of the dwell so they have settled.
  assign sample_s   = &scan_q[SCAN_BITS-3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q      <= '0;
      col_sel_n_q <= COL0_N;
    end else begin
      scan_q      <= scan_d;
      col_sel_n_q <= col_code(col_next_s);
    end
  end

  genvar k;
  generate
    for (k = 0; k < 16; k++) begin : g_key
      localparam logic [3:0] KI = 4'(k);
      key_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_deb (
        .clk         (clk),
        .rst         (rst),
        .sample_en_i (sample_s && (col_s == KI[3:2])),
        .raw_i       (~rows_n[KI[1:0]]),
        .stable_o    (stable_s[k]),
        .press_o     (press_s[k])
      );
    end
  endgenerate

  assign cab_set_s  = press_s[{KEY_CAB_COL, 2'd3} -: 4];
  assign up_set_s   = {1'b0, press_s[{KEY_UP_COL, 2'd2} -: 3]};
  assign down_set_s = {press_s[{KEY_DOWN_COL, 2'd3} -: 3], 1'b0};
  assign clr_mask_s = bus.clr_valid ? (4'b0001 << bus.clr_floor) : 4'b0000;

  // Set is applied after clear, so a same-cycle set wins.
  always_comb begin
    req_d      = req_q;
    req_d.cab  = (req_q.cab  & ~clr_mask_s) | cab_set_s;
    req_d.up   = (req_q.up   & ~clr_mask_s) | up_set_s;
    req_d.down = (req_q.down & ~clr_mask_s) | down_set_s;
    any_d      = |{req_d.cab, req_d.up, req_d.down};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      any_q   <= 1'b0;
      stop_q  <= 1'b0;
      open_q  <= 1'b0;
      close_q <= 1'b0;
    end else begin
      req_q   <= req_d;
      any_q   <= any_d;
      stop_q  <= press_s[key_idx(KEY_STOP_COL, KEY_STOP_ROW)];
      open_q  <= press_s[key_idx(KEY_DOOR_OPEN_COL, KEY_DOOR_OPEN_ROW)];
      close_q <= press_s[key_idx(KEY_DOOR_CLOSE_COL, KEY_DOOR_CLOSE_ROW)];
    end
  end

  // Column 3 rows 1..3 are wired but carry no function.
  assign unused_s = ^{press_s[15:13], stable_s};

  assign col_sel_n            = col_sel_n_q;
  assign bus.cab_req          = req_q.cab;
  assign bus.up_req           = req_q.up;
  assign bus.down_req         = req_q.down;
  assign bus.any_req          = any_q;
  assign bus.stop_pulse       = stop_q;
  assign bus.door_open_pulse  = open_q;
  assign bus.door_close_pulse = close_q;

endmodule
